// File: rtl/iic_slave_pkg.sv
// Shared definitions for the IIC EEPROM target: FSM state encoding,
// 24Cxx device type code and ACK/NACK bus levels.
package iic_slave_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_DEV        = 4'd1,
        S_DEV_ACK    = 4'd2,
        S_ADDR_H     = 4'd3,
        S_ADDR_H_ACK = 4'd4,
        S_ADDR_L     = 4'd5,
        S_ADDR_L_ACK = 4'd6,
        S_WDATA      = 4'd7,
        S_WDATA_ACK  = 4'd8,
        S_RDATA      = 4'd9,
        S_RDATA_ACK  = 4'd10,
        S_WAIT_STOP  = 4'd11
    } t_state;

    localparam logic [3:0] C_DEV_TYPE = 4'b1010;
    localparam logic       C_SDA_ACK  = 1'b0;
    localparam logic       C_SDA_NACK = 1'b1;

    // Open-drain: presenting a low level means enabling the pull-down.
    function automatic logic oe_for(input logic i_level);
        return ~i_level;
    endfunction

endpackage

// File: rtl/iic_slave_sync_edge.sv
// Synchronizes SCL/SDA into i_clk and derives SCL edge and START/STOP pulses.
module iic_slave_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // [0],[1] are the synchronizer stages, [2] is the previous sample for edges.
    logic [2:0] r_scl;
    logic [2:0] r_sda;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            r_scl <= {r_scl[1:0], i_scl};
            r_sda <= {r_sda[1:0], i_sda};
        end
    end

    assign o_sda      = r_sda[1];
    assign o_scl_rise = r_scl[1] & ~r_scl[2];
    assign o_scl_fall = ~r_scl[1] & r_scl[2];
    assign o_start    = r_scl[1] & r_scl[2] & ~r_sda[1] & r_sda[2];
    assign o_stop     = r_scl[1] & r_scl[2] & r_sda[1] & ~r_sda[2];

endmodule

// File: rtl/iic_eeprom_slave.sv
// 24Cxx-style I2C EEPROM target with 16-bit word address and on-chip byte array.
// Define EEPROM_SLAVE_WP_EN to add the i_wp write-protect input.
module iic_eeprom_slave #(
    parameter logic [2:0] P_DEV_ADDR  = 3'b000,
    parameter int         P_ADDR_W    = 8,
    parameter int         P_MEM_DEPTH = 2**P_ADDR_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
`ifdef EEPROM_SLAVE_WP_EN
    input  logic i_wp,
`endif
    output logic o_sda_oe,
    output logic o_busy,
    output logic o_wr_strobe
);
    import iic_slave_pkg::*;

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_wp, w_byte_done, w_dev_match, w_mem_we;
    logic [P_ADDR_W-1:0] w_ptr_next, w_rd_addr;
    logic [7:0]          w_rd_byte;

    t_state              r_state;
    logic [3:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_addr_h;
    logic [P_ADDR_W-1:0] r_ptr;
    logic                r_rw;
    logic                r_mack;
    logic                r_sda_oe;
    logic                r_busy;
    logic                r_wr_strobe;

    // Unprogrammed EEPROM content; reset deliberately leaves the array alone.
    logic [7:0] r_mem [P_MEM_DEPTH] = '{default: 8'hFF};

    iic_slave_sync_edge u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

`ifdef EEPROM_SLAVE_WP_EN
    assign w_wp = i_wp;
`else
    assign w_wp = 1'b0;
`endif

    assign w_byte_done = (r_bit_cnt == 4'd8);
    assign w_dev_match = (r_shift[7:1] == {C_DEV_TYPE, P_DEV_ADDR});
    assign w_ptr_next  = (r_ptr == P_ADDR_W'(P_MEM_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    // While the master acknowledges, the next byte is fetched ahead of the pointer update.
    assign w_rd_addr   = (r_state == S_RDATA_ACK) ? w_ptr_next : r_ptr;
    assign w_rd_byte   = r_mem[w_rd_addr];
    assign w_mem_we    = (r_state == S_WDATA) && w_scl_fall && w_byte_done &&
                         !w_start && !w_stop && !w_wp;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[r_ptr] <= r_shift;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_addr_h    <= '0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_mack      <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state   <= S_DEV;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV, S_ADDR_H, S_ADDR_L, S_WDATA: begin
                        if (w_scl_rise && !w_byte_done) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && w_byte_done) begin
                            r_bit_cnt <= '0;
                            case (r_state)
                                S_DEV: begin
                                    if (w_dev_match) begin
                                        r_state  <= S_DEV_ACK;
                                        r_rw     <= r_shift[0];
                                        r_busy   <= 1'b1;
                                        r_sda_oe <= oe_for(C_SDA_ACK);
                                    end else begin
                                        r_state  <= S_WAIT_STOP;
                                    end
                                end
                                S_ADDR_H: begin
                                    r_addr_h <= r_shift;
                                    r_state  <= S_ADDR_H_ACK;
                                    r_sda_oe <= oe_for(C_SDA_ACK);
                                end
                                S_ADDR_L: begin
                                    r_ptr    <= P_ADDR_W'({r_addr_h, r_shift});
                                    r_state  <= S_ADDR_L_ACK;
                                    r_sda_oe <= oe_for(C_SDA_ACK);
                                end
                                default: begin
                                    r_state     <= S_WDATA_ACK;
                                    r_ptr       <= w_ptr_next;
                                    r_sda_oe    <= oe_for(w_wp ? C_SDA_NACK : C_SDA_ACK);
                                    r_wr_strobe <= !w_wp;
                                end
                            endcase
                        end
                    end
                    S_DEV_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_rw) begin
                                r_state  <= S_RDATA;
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= oe_for(w_rd_byte[7]);
                            end else begin
                                r_state  <= S_ADDR_H;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_H_ACK: begin
                        if (w_scl_fall) begin
                            r_state  <= S_ADDR_L;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    S_ADDR_L_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_state  <= S_WDATA;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise && !w_byte_done) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (w_byte_done) begin
                                r_state  <= S_RDATA_ACK;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= oe_for(r_shift[6]);
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= (w_sda == C_SDA_ACK);
                        end else if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_mack) begin
                                r_ptr    <= w_ptr_next;
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= oe_for(w_rd_byte[7]);
                                r_state  <= S_RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_busy      = r_busy;
    assign o_wr_strobe = r_wr_strobe;

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Bench for iic_eeprom_slave: bit-level I2C master tasks, byte-array reference
// model with an expected-read queue, directed vectors and randomized transactions.
`timescale 1ns/1ps
module tb_iic_eeprom_slave;

    localparam logic [7:0] DEV_W = 8'hA0;
    localparam logic [7:0] DEV_R = 8'hA1;
    localparam logic [7:0] BAD_W = 8'hA6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_bus;
    logic o_sda_oe, o_busy, o_wr_strobe;
`ifdef EEPROM_SLAVE_WP_EN
    logic wp = 1'b0;
`endif

    assign sda_bus = sda_m & ~o_sda_oe;

    iic_eeprom_slave dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl),
        .i_sda       (sda_bus),
`ifdef EEPROM_SLAVE_WP_EN
        .i_wp        (wp),
`endif
        .o_sda_oe    (o_sda_oe),
        .o_busy      (o_busy),
        .o_wr_strobe (o_wr_strobe)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitors ----------------
    int strobe_cnt = 0;
    int oe_hi_cnt  = 0;
    always @(negedge clk) begin
        if (o_wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (o_sda_oe)    oe_hi_cnt  <= oe_hi_cnt + 1;
    end

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mdl_mem [256];
    logic [7:0] mdl_ptr;
    logic [7:0] wr_buf [4];
    logic [7:0] last_rd;
    logic       oe_pre, oe_post;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- bus driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(3);
        scl = 1'b1;   tick(3);
        sda_m = 1'b0; tick(3);
        scl = 1'b0;   tick(3);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(3);
        scl = 1'b1;   tick(3);
        sda_m = 1'b1; tick(6);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;  tick(3);
        scl = 1'b1; tick(6);
        scl = 1'b0; tick(3);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; tick(3);
        scl = 1'b1;   tick(3);
        b = sda_bus;  tick(3);
        scl = 1'b0;   tick(3);
    endtask

    // Last data bit is hand-clocked to record oe two and three cycles after SCL falls.
    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic bit_v;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        sda_m = b[0]; tick(3);
        scl = 1'b1;   tick(6);
        scl = 1'b0;   tick(2);
        oe_pre = o_sda_oe; tick(1);
        oe_post = o_sda_oe;
        recv_bit(bit_v);
        ack = ~bit_v;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bit_v);
            d[i] = bit_v;
        end
        send_bit(ack ? 1'b0 : 1'b1);
    endtask

    // ---------------- transactions ----------------
    task automatic do_write(input logic [15:0] addr, input int len, input logic wp_on);
        int s0;
        logic ack;
        logic [7:0] a;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(DEV_W, ack);
        check("wr_dev_ack", 32'(ack), 1);
        check("ack_drive_latency", 32'({oe_pre, oe_post}), 32'h1);
        check("busy_in_frame", 32'(o_busy), 1);
        write_byte(addr[15:8], ack);
        check("wr_addrh_ack", 32'(ack), 1);
        write_byte(addr[7:0], ack);
        check("wr_addrl_ack", 32'(ack), 1);
        for (int i = 0; i < len; i++) begin
            write_byte(wr_buf[i], ack);
            check("wr_data_ack", 32'(ack), 32'(!wp_on));
        end
        i2c_stop();
        check("wr_strobes", 32'(strobe_cnt - s0), wp_on ? 0 : 32'(len));
        check("busy_after_stop", 32'(o_busy), 0);
        a = addr[7:0];
        for (int i = 0; i < len; i++) begin
            if (!wp_on) mdl_mem[a] = wr_buf[i];
            a = a + 8'd1;
        end
        mdl_ptr = a;
    endtask

    task automatic do_read(input logic use_addr, input logic [15:0] addr, input int len);
        logic ack;
        logic [7:0] p, d;
        if (use_addr) begin
            i2c_start();
            write_byte(DEV_W, ack);
            check("rd_devw_ack", 32'(ack), 1);
            write_byte(addr[15:8], ack);
            check("rd_addrh_ack", 32'(ack), 1);
            write_byte(addr[7:0], ack);
            check("rd_addrl_ack", 32'(ack), 1);
        end
        i2c_start();
        write_byte(DEV_R, ack);
        check("rd_devr_ack", 32'(ack), 1);
        p = use_addr ? addr[7:0] : mdl_ptr;
        for (int i = 0; i < len; i++) exp_q.push_back(mdl_mem[p + 8'(i)]);
        for (int i = 0; i < len; i++) begin
            read_byte(d, i < len - 1);
            check("rd_data", 32'(d), 32'(exp_q.pop_front()));
            last_rd = d;
        end
        check("rd_release_after_nack", 32'(o_sda_oe), 0);
        i2c_stop();
        mdl_ptr = p + 8'(len - 1);
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [15:0] wr_addr;
        logic [15:0] rd_addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t vecs[4];

    initial begin
        logic ack;
        logic bit_v;
        int o0, s0;
        logic [7:0] v40;

        vecs[0] = '{wr_addr: 16'h0010, rd_addr: 16'h0010, data: 8'hA5, exp_rd: 8'hA5};
        vecs[1] = '{wr_addr: 16'h1F33, rd_addr: 16'h0033, data: 8'h3C, exp_rd: 8'h3C};
        vecs[2] = '{wr_addr: 16'h00FF, rd_addr: 16'h00FF, data: 8'h00, exp_rd: 8'h00};
        vecs[3] = '{wr_addr: 16'h0080, rd_addr: 16'h0081, data: 8'h5A, exp_rd: 8'hFF};

        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'hFF;
        mdl_ptr = 8'h00;

        tick(5);
        check("rst_oe", 32'(o_sda_oe), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_strobe", 32'(o_wr_strobe), 0);
        rst = 1'b0;
        tick(5);

        // Table: byte write then random read.
        for (int i = 0; i < 4; i++) begin
            wr_buf[0] = vecs[i].data;
            do_write(vecs[i].wr_addr, 1, 1'b0);
            do_read(1'b1, vecs[i].rd_addr, 1);
            check("vec_rd", 32'(last_rd), 32'(vecs[i].exp_rd));
        end

        // Wrong device address: no ACK anywhere and no write until STOP.
        o0 = oe_hi_cnt;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(BAD_W, ack);
        check("bad_dev_nack", 32'(ack), 0);
        check("bad_dev_busy", 32'(o_busy), 0);
        write_byte(8'h00, ack);
        check("bad_addrh_nack", 32'(ack), 0);
        write_byte(8'h10, ack);
        check("bad_addrl_nack", 32'(ack), 0);
        write_byte(8'h77, ack);
        check("bad_data_nack", 32'(ack), 0);
        i2c_stop();
        check("bad_dev_oe_never", 32'(oe_hi_cnt - o0), 0);
        check("bad_dev_no_strobe", 32'(strobe_cnt - s0), 0);
        do_read(1'b1, 16'h0010, 1);
        check("bad_dev_mem_kept", 32'(last_rd), 32'hA5);

        // Page write across the top of the array, then sequential and current reads.
        wr_buf[0] = 8'h01; wr_buf[1] = 8'h02; wr_buf[2] = 8'h03; wr_buf[3] = 8'h04;
        do_write(16'h00FE, 4, 1'b0);
        do_read(1'b1, 16'h00FE, 3);
        check("seq_last", 32'(last_rd), 32'h03);
        do_read(1'b0, 16'h0000, 1);
        check("cur_after_nack", 32'(last_rd), 32'h03);
        do_read(1'b1, 16'h0001, 1);
        check("page_wrap_01", 32'(last_rd), 32'h04);

`ifdef EEPROM_SLAVE_WP_EN
        wp = 1'b1;
        wr_buf[0] = 8'h5A;
        do_write(16'h0020, 1, 1'b1);
        wp = 1'b0;
        do_read(1'b1, 16'h0020, 1);
        check("wp_kept", 32'(last_rd), 32'hFF);
`endif

        // Reset during bit 4 of a write data byte: nothing stored.
        v40 = mdl_mem[8'h40];
        s0 = strobe_cnt;
        i2c_start();
        write_byte(DEV_W, ack);
        write_byte(8'h00, ack);
        write_byte(8'h40, ack);
        send_bit(~v40[7]); send_bit(~v40[6]); send_bit(~v40[5]);
        sda_m = ~v40[4]; tick(3);
        scl = 1'b1; tick(2);
        rst = 1'b1; #1;
        check("rst_wr_oe", 32'(o_sda_oe), 0);
        tick(1);
        scl = 1'b0; tick(3);
        rst = 1'b0; tick(3);
        i2c_stop();
        check("rst_wr_no_strobe", 32'(strobe_cnt - s0), 0);
        mdl_ptr = 8'h00;
        do_read(1'b1, 16'h0040, 1);
        check("rst_wr_mem_kept", 32'(last_rd), 32'(v40));

        // Reset while the target is pulling SDA low during a read: released without a clock.
        wr_buf[0] = 8'h00;
        do_write(16'h0030, 1, 1'b0);
        i2c_start();
        write_byte(DEV_W, ack);
        write_byte(8'h00, ack);
        write_byte(8'h30, ack);
        i2c_start();
        write_byte(DEV_R, ack);
        for (int i = 0; i < 3; i++) begin
            recv_bit(bit_v);
            check("rd0_bit", 32'(bit_v), 0);
        end
        sda_m = 1'b1; tick(3);
        scl = 1'b1; tick(3);
        check("rd0_bit_drive", 32'(o_sda_oe), 1);
        #2;
        rst = 1'b1; #1;
        check("rst_rd_oe_async", 32'(o_sda_oe), 0);
        tick(1);
        scl = 1'b0; tick(3);
        rst = 1'b0; tick(3);
        i2c_stop();
        check("rst_rd_busy", 32'(o_busy), 0);
        mdl_ptr = 8'h00;
        do_read(1'b0, 16'h0000, 1);

        // Randomized transactions against the byte-array model.
        for (int n = 0; n < 20; n++) begin
            int op, len;
            logic [15:0] addr;
            op   = $urandom_range(0, 2);
            len  = $urandom_range(1, 4);
            addr = 16'($urandom);
            if (op == 0) begin
                for (int i = 0; i < 4; i++) wr_buf[i] = 8'($urandom);
                do_write(addr, len, 1'b0);
            end else if (op == 1) begin
                do_read(1'b1, addr, len);
            end else begin
                do_read(1'b0, addr, len);
            end
        end

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iic_eeprom_slave.md
# iic_eeprom_slave

I2C target model of a 24Cxx-style EEPROM with a 16-bit word address and an on-chip byte array. It is the responder for the board-level IIC master that the EEPROM controller drives. It is used in the capture-card bench and on-FPGA loopback to close the write/read path without a physical EEPROM. It samples SCL/SDA with the system clock and drives SDA open-drain via an output-enable.

## Interface
Parameters:
- P_DEV_ADDR, 3'b000, A2..A0 pins; the full 7-bit device address is {4'b1010, P_DEV_ADDR}.
- P_ADDR_W, 8, number of memory index bits.
- P_MEM_DEPTH, 2**P_ADDR_W, number of bytes stored.

Ports:
- i_clk  in  1  system clock; reset i_rst, asynchronous, active-high; clock i_clk.
- i_rst  in  1  asynchronous active-high reset.
- i_scl  in  1  I2C clock from the bus, asynchronous to i_clk.
- i_sda  in  1  I2C data from the bus, asynchronous to i_clk.
- o_sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- o_busy  out  1  high from an addressed START until STOP.
- o_wr_strobe  out  1  one-cycle pulse when a data byte is committed to memory.
- i_wp  in  1  write protect; present only with EEPROM_SLAVE_WP_EN.

## Operation
- Input conditioning: 2-flop synchronizer on each line, plus a third register for edge detection.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data is sampled on the SCL rising edge and driven after the SCL falling edge.
- States: IDLE, DEV, DEV_ACK, ADDR_H, ADDR_H_ACK, ADDR_L, ADDR_L_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- Transitions:
  - START from any state goes to DEV. Repeated START is legal and bit_cnt clears to 0.
  - STOP from any state goes to IDLE and releases SDA.
  - DEV: 8 bits, MSB first.
    - Bits [7:1] must equal {1010, P_DEV_ADDR}. A mismatch goes to WAIT_STOP with no ACK; SDA stays released.
    - A match goes to DEV_ACK and drives ACK.
    - After ACK: R/W = 0 goes to ADDR_H; R/W = 1 goes to RDATA.
  - ADDR_H, then ADDR_L: each receives 8 bits and is ACKed. The pointer is {ADDR_H, ADDR_L}[P_ADDR_W-1:0]; higher bits are ignored.
  - WDATA: 8 bits go to WDATA_ACK, which ACKs, writes mem[ptr], pulses o_wr_strobe and increments ptr. Returns to WDATA for the next byte.
  - RDATA: shifts out mem[ptr] MSB first. A 0 bit sets oe = 1; a 1 bit sets oe = 0.
  - RDATA_ACK: releases SDA and samples the master on the 9th rising edge.
    - ACK (SDA low): ptr increments, then RDATA with the next byte.
    - NACK: goes to WAIT_STOP.
- ptr wraps modulo P_MEM_DEPTH: from P_MEM_DEPTH-1 to 0, for both writes and reads.
- ptr persists across transactions, so a current-address read works.
- Reset values:
  - o_sda_oe = 0, o_busy = 0, o_wr_strobe = 0.
  - State IDLE, ptr = 0, bit_cnt = 0.
  - Memory is not cleared by reset. Its initial content is 8'hFF.
- Reset in the middle of a transfer releases SDA immediately, because the reset is asynchronous. No partial byte is written.

## Timing
- Requires i_clk ≥ 8× SCL.
- Input latency: 2 i_clk cycles of synchronizer plus 1 cycle of edge detection.
- o_sda_oe changes exactly 1 i_clk after the detected SCL falling edge. This gives ≥3 i_clk of hold after the bus edge.
- ACK: oe = 1 after the falling edge that ends bit 8; oe = 0 after the falling edge that ends bit 9.
- Read data byte:
  - Loaded from mem[ptr] on the falling edge that ends the preceding ACK.
  - Bit 7 is driven in that same cycle.
- o_wr_strobe fires in the cycle after the falling edge of bit 8 of a data byte, together with the ACK drive.
- START and a SCL edge in the same cycle: START has priority.
- o_busy is set 1 cycle after the DEV address matches. It clears 1 cycle after STOP is detected.

## Configuration
- EEPROM_SLAVE_WP_EN defined:
  - i_wp is present.
  - When i_wp = 1, data bytes are NACKed in WDATA_ACK, nothing is written, o_wr_strobe stays 0 and ptr still increments.
  - Device-address and word-address bytes are always ACKed.
- Not defined: there is no i_wp port and all writes are stored.

## Structure
- Package iic_slave_pkg holds:
  - the state encodings;
  - the device type code 4'b1010;
  - the ACK/NACK constants.
- Sub-module iic_slave_sync_edge: synchronizers plus scl_rise, scl_fall, start_det and stop_det pulses.
- Top level: FSM, bit counter, shift register, pointer and memory array (inferred RAM, one write port, one read port).

## Test plan
- Byte write of 8'hA5 to address 16'h0010, then a random read of 16'h0010 → ACK on all 4 bytes; the read returns 8'hA5; o_wr_strobe pulses once.
- Device address 7'b1010_011 while P_DEV_ADDR = 0 → no ACK (oe stays 0 for the whole frame) and no state change until STOP.
- Page write of 4 bytes starting at 8'hFE, values 01, 02, 03, 04 → mem[FE] = 01, mem[FF] = 02, mem[00] = 03, mem[01] = 04 (wrap).
- Sequential read of 3 bytes from 8'hFE with the master NACKing the 3rd byte → returns 01, 02, 03; SDA is released after the NACK; ptr = 8'h00.
- i_rst asserted during bit 4 of a data byte → o_sda_oe = 0 the same cycle; mem is unchanged; the next transaction completes normally.
- With EEPROM_SLAVE_WP_EN and i_wp = 1, write 8'h5A to 16'h0020 → address bytes ACKed, data byte NACKed; a read of 16'h0020 returns the prior value 8'hFF.
